apb_cmd_sequencer: RTL and testbench

Upstream feeder for the APB master: buffers host read/write commands in a small FIFO and presents them one at a time on the master's request inputs (write flag, address, write data). It holds each request stable until the slave signals completion via PREADY. It captures read data from the master into a response register with a valid/ready handshake. It lets software or a test driver queue a burst of register accesses without tracking APB phase timing.

---
 rtl/apb_cmd_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_apb_cmd_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_sequencer.sv
// ============================================================================
// Module   : apb_cmd_sequencer
// Purpose  : Buffers host read/write commands in a small FIFO and presents
//            them one at a time to an APB master. Each request is held until
//            the slave signals PREADY. Read data is returned through a
//            valid/ready response register, strictly in command order.
// Options  : APB_SEQ_TIMEOUT_EN - abort an ACCESS phase after TIMEOUT cycles
//            without PREADY (reads return rdata=0 with rsp_err=1, writes are
//            dropped). Without it, ACCESS waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              PWRITE_MASTER,
  output logic [ADDR_W-1:0] PADDR_MASTER,
  output logic [DATA_W-1:0] PWDATA_MASTER,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA_MASTER,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_PTR_W = c_IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Command FIFO storage and wrap-bit pointers
  logic              r_fifo_write [DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr  [DEPTH];
  logic [DATA_W-1:0] r_fifo_wdata [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // FSM control strobes
  logic w_xfer_end;
  logic w_rsp_load;
  logic w_rsp_abort;
  logic w_rsp_clear;
  logic w_tmo;

  // Registered master-side and response-side outputs
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  // Full when the index bits match but the wrap bits differ
  assign w_full  = (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]) &&
                   (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // No bypass: a pop in the same cycle does not make room for a push when full
  assign w_push    = cmd_valid && !w_full;
  assign cmd_ready = !w_full;
  assign busy      = (r_state != S_IDLE) || !w_empty;

  // FIFO storage write (no reset needed; contents qualified by the pointers)
  always_ff @(posedge PCLK) begin
    if (w_push) begin
      r_fifo_write[r_wr_ptr[c_IDX_W-1:0]] <= cmd_write;
      r_fifo_addr [r_wr_ptr[c_IDX_W-1:0]] <= cmd_addr;
      r_fifo_wdata[r_wr_ptr[c_IDX_W-1:0]] <= cmd_wdata;
    end
  end

  // FIFO pointer update
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
    end
  end

`ifdef APB_SEQ_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT + 1);

  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               r_rsp_err;

  // Abort fires on the TIMEOUT-th ACCESS cycle still lacking PREADY
  assign w_tmo   = (r_state == S_ACCESS) && (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));
  assign rsp_err = r_rsp_err;

  // ACCESS cycle counter, cleared whenever a new transfer is issued
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tmo_cnt <= '0;
    end else if (w_pop) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !w_xfer_end) begin
      r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
    end
  end

  // Error flag accompanies each loaded response
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_rsp_err <= 1'b0;
    end else if (w_rsp_load) begin
      r_rsp_err <= w_rsp_abort;
    end
  end
`else
  logic w_unused_cfg;

  assign w_tmo        = 1'b0;
  assign rsp_err      = 1'b0;
  assign w_unused_cfg = (TIMEOUT > 0);
`endif

  // FSM state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_xfer_end  = 1'b0;
    w_rsp_load  = 1'b0;
    w_rsp_abort = 1'b0;
    w_rsp_clear = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (PREADY || w_tmo) begin
          w_xfer_end = 1'b1;
          if (r_pwrite) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_rsp_load  = 1'b1;
            w_rsp_abort = !PREADY;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_clear = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Master request registers: load on issue, direction drops between transfers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_pop) begin
      r_pwrite <= r_fifo_write[r_rd_ptr[c_IDX_W-1:0]];
      r_paddr  <= r_fifo_addr [r_rd_ptr[c_IDX_W-1:0]];
      r_pwdata <= r_fifo_wdata[r_rd_ptr[c_IDX_W-1:0]];
    end else if (w_xfer_end) begin
      r_pwrite <= 1'b0;
    end
  end

  // Read response register with valid/ready handshake
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_rsp_load) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= w_rsp_abort ? '0 : PRDATA_MASTER;
    end else if (w_rsp_clear) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign PWRITE_MASTER = r_pwrite;
  assign PADDR_MASTER  = r_paddr;
  assign PWDATA_MASTER = r_pwdata;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_cmd_sequencer.sv
// ============================================================================
// Module   : tb_apb_cmd_sequencer
// Purpose  : Self-checking bench for apb_cmd_sequencer. A queue-based
//            transaction model predicts every output each cycle; directed
//            sequences add literal expectations for write order, read data,
//            backpressure, response stall, reset and (APB_SEQ_TIMEOUT_EN)
//            timeout behaviour.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              PCLK   = 1'b0;
  logic              PRESET = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr  = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              PWRITE_MASTER;
  logic [ADDR_W-1:0] PADDR_MASTER;
  logic [DATA_W-1:0] PWDATA_MASTER;
  logic              PREADY = 1'b0;
  logic [DATA_W-1:0] PRDATA_MASTER;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  apb_cmd_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .PWRITE_MASTER(PWRITE_MASTER), .PADDR_MASTER(PADDR_MASTER),
    .PWDATA_MASTER(PWDATA_MASTER), .PREADY(PREADY),
    .PRDATA_MASTER(PRDATA_MASTER),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- simple slave: 4-word register file ----------------
  logic [31:0] slave_mem [4];
  logic [31:0] wr_log_a[$];
  logic [31:0] wr_log_d[$];
  logic [31:0] rsp_log_d[$];
  logic        rsp_log_e[$];

  assign PRDATA_MASTER = slave_mem[PADDR_MASTER[3:2]];

  initial begin
    for (int i = 0; i < 4; i++) slave_mem[i] = 32'h0;
    forever begin
      @(posedge PCLK);
      if (!PRESET && PWRITE_MASTER && PREADY) begin
        slave_mem[PADDR_MASTER[3:2]] = PWDATA_MASTER;
        wr_log_a.push_back(PADDR_MASTER);
        wr_log_d.push_back(PWDATA_MASTER);
      end
      if (!PRESET && rsp_valid && rsp_ready) begin
        rsp_log_d.push_back(rsp_rdata);
        rsp_log_e.push_back(rsp_err);
      end
    end
  end

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  cmd_t        mq[$];
  cmd_t        mhead;
  int          mph = 0;        // 0: no transfer, 1: transfer outstanding, 2: response waiting
  int          mwait = 0;
  logic        mpush;
  logic        exp_pwrite = 1'b0;
  logic [31:0] exp_paddr  = '0;
  logic [31:0] exp_pwdata = '0;
  logic        exp_rvalid = 1'b0;
  logic [31:0] exp_rdata  = '0;
  logic        exp_rerr   = 1'b0;

  task automatic model_finish(input logic abort);
    if (mhead.w) begin
      mph = 0;
    end else begin
      exp_rvalid = 1'b1;
      exp_rdata  = abort ? 32'h0 : PRDATA_MASTER;
      exp_rerr   = abort;
      mph = 2;
    end
    exp_pwrite = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge PCLK or posedge PRESET);
      if (PRESET) begin
        mq.delete();
        mph = 0; mwait = 0;
        exp_pwrite = 1'b0; exp_paddr = '0; exp_pwdata = '0;
        exp_rvalid = 1'b0; exp_rdata = '0; exp_rerr = 1'b0;
      end else begin
        mpush = cmd_valid && (mq.size() < DEPTH);
        case (mph)
          0: if (mq.size() > 0) begin
               mhead = mq.pop_front();
               exp_pwrite = mhead.w;
               exp_paddr  = mhead.a;
               exp_pwdata = mhead.d;
               mph = 1;
               mwait = 0;
             end
          1: if (PREADY) begin
               model_finish(1'b0);
             end else begin
`ifdef APB_SEQ_TIMEOUT_EN
               mwait++;
               if (mwait == TIMEOUT) model_finish(1'b1);
`endif
             end
          2: if (rsp_ready) begin
               exp_rvalid = 1'b0;
               mph = 0;
             end
          default: mph = 0;
        endcase
        if (mpush) mq.push_back('{cmd_write, cmd_addr, cmd_wdata});
      end
    end
  end

  // Per-cycle compare of every output against the model
  initial begin
    forever begin
      @(negedge PCLK);
      if (chk_en) begin
        check("cmd_ready", cmd_ready, (mq.size() < DEPTH));
        check("busy", busy, (mph != 0) || (mq.size() > 0));
        check("PWRITE_MASTER", PWRITE_MASTER, exp_pwrite);
        check("PADDR_MASTER", PADDR_MASTER, exp_paddr);
        check("PWDATA_MASTER", PWDATA_MASTER, exp_pwdata);
        check("rsp_valid", rsp_valid, exp_rvalid);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_rerr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge PCLK);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    int   n;
    logic acc;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    forever begin
      acc = cmd_ready;
      tick();
      if (acc) break;
      n++;
      if (n > 200) begin
        n_chk++; n_fail++;
        $display("FAIL push_timeout actual=stalled required=accepted addr=%0h", a);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy !== 1'b0 && n <= bound) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  logic [31:0] exp_wa [10];
  logic [31:0] exp_wd [10];
  logic [31:0] exp_rd [6];
  int          base;

  initial begin
    exp_wa = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4};
    exp_wd = '{32'd23, 32'h20122023, 32'h98A0A1A0, 32'h85AAA0E2,
               32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    exp_rd = '{32'd23, 32'h20122023, 32'h98A0A1A0, 32'h85AAA0E2, 32'h33, 32'h44};

    // Reset values
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_pwrite", PWRITE_MASTER, 1'b0);
    check("rst_paddr", PADDR_MASTER, 32'h0);
    check("rst_pwdata", PWDATA_MASTER, 32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    PRESET = 1'b0;
    chk_en = 1'b1;

    // Four writes, slave always ready
    PREADY = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, exp_wa[i], exp_wd[i]);
    wait_idle(50);
    check("wr_count", wr_log_a.size(), 4);
    for (int i = 0; i < 4 && i < wr_log_a.size(); i++) begin
      check("wr_addr", wr_log_a[i], exp_wa[i]);
      check("wr_data", wr_log_d[i], exp_wd[i]);
    end
    check("no_rsp_after_writes", rsp_log_d.size(), 0);

    // Four reads back, responses in order
    for (int i = 0; i < 4; i++) push_cmd(1'b0, exp_wa[i], 32'hDEAD0000 + i);
    wait_idle(50);
    check("rd_count", rsp_log_d.size(), 4);
    for (int i = 0; i < 4 && i < rsp_log_d.size(); i++) begin
      check("rd_data", rsp_log_d[i], exp_rd[i]);
      check("rd_err", rsp_log_e[i], 1'b0);
    end

    // Backpressure: PREADY low, fill the FIFO behind one outstanding transfer
    PREADY = 1'b0;
    for (int i = 4; i < 9; i++) push_cmd(1'b1, exp_wa[i], exp_wd[i]);
    check("full_cmd_ready", cmd_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    fork
      begin repeat (5) tick(); PREADY = 1'b1; end
      push_cmd(1'b1, exp_wa[9], exp_wd[9]);
    join
    wait_idle(60);
    check("bp_wr_count", wr_log_a.size(), 10);
    for (int i = 4; i < 10 && i < wr_log_a.size(); i++) begin
      check("bp_wr_addr", wr_log_a[i], exp_wa[i]);
      check("bp_wr_data", wr_log_d[i], exp_wd[i]);
    end

    // Response held with rsp_ready low: next read must not issue
    rsp_ready = 1'b0;
    push_cmd(1'b0, 32'h8, 32'h0);
    push_cmd(1'b0, 32'hC, 32'h0);
    for (int n = 0; n < 20 && rsp_valid !== 1'b1; n++) tick();
    for (int n = 0; n < 10; n++) begin
      check("hold_rsp_valid", rsp_valid, 1'b1);
      check("hold_rsp_rdata", rsp_rdata, 32'h33);
      check("hold_paddr", PADDR_MASTER, 32'h8);
      tick();
    end
    rsp_ready = 1'b1;
    wait_idle(50);
    check("hold_rd_count", rsp_log_d.size(), 6);
    for (int i = 4; i < 6 && i < rsp_log_d.size(); i++)
      check("hold_rd_data", rsp_log_d[i], exp_rd[i]);

    // Reset during ACCESS with three commands still queued
    PREADY = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(1'b0, exp_wa[i], 32'h0);
    check("pre_rst_busy", busy, 1'b1);
    PRESET = 1'b1;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check("mid_rst_pwrite", PWRITE_MASTER, 1'b0);
    check("mid_rst_paddr", PADDR_MASTER, 32'h0);
    check("mid_rst_pwdata", PWDATA_MASTER, 32'h0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    check("mid_rst_busy", busy, 1'b0);
    tick();
    PRESET = 1'b0;
    PREADY = 1'b1;
    repeat (6) tick();
    check("post_rst_no_rsp", rsp_log_d.size(), 6);
    check("post_rst_busy", busy, 1'b0);

`ifdef APB_SEQ_TIMEOUT_EN
    // Timeout: read aborts with error, write is silently dropped
    PREADY = 1'b0;
    base = wr_log_a.size();
    push_cmd(1'b0, 32'h4, 32'h0);
    push_cmd(1'b1, 32'h8, 32'hBAD0BAD0);
    wait_idle(100);
    check("tmo_rsp_count", rsp_log_d.size(), 7);
    if (rsp_log_d.size() == 7) begin
      check("tmo_rsp_rdata", rsp_log_d[6], 32'h0);
      check("tmo_rsp_err", rsp_log_e[6], 1'b1);
    end
    check("tmo_wr_dropped", wr_log_a.size(), base);
    check("tmo_mem_intact", slave_mem[2], 32'h33);
    PREADY = 1'b1;
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
